// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue: circular buffer of {instr, pc} pairs
//
// Purpose:
//   Buffers fetched instruction pairs between the fetch stage and decode.
//   Writes always land as a pair of two entries. Decode reads the two oldest
//   entries combinationally and retires 0, 1 or 2 of them per cycle.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       fetch pair valid
//   wr_data     {instr1, pc1, instr0, pc0}, pair 0 older in program order
//   flush       jump redirect, empties the queue
//   deq_cnt     entries consumed by decode at this edge (3 acts as 2)
//   instr0/pc0  oldest entry (0 when valid0 is low)
//   instr1/pc1  second-oldest entry (0 when valid1 is low)
//   valid0/1    entry 0 / entry 1 present
//   count       current occupancy
//   stop_fetch  backpressure to fetch when free space drops below AF_MARGIN
//   drop_err    one-cycle pulse after a write was rejected for lack of space

module fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [127:0]               wr_data,
  input  logic                       flush,
  input  logic [1:0]                 deq_cnt,
  output logic [31:0]                instr0,
  output logic [31:0]                pc0,
  output logic [31:0]                instr1,
  output logic [31:0]                pc1,
  output logic                       valid0,
  output logic                       valid1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stop_fetch,
  output logic                       drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          drop_q;

  logic [CW-1:0] free_slots;
  logic          space_ok;
  logic          wr_acc;
  logic          wr_drop;
  logic [CW-1:0] deq_req;
  logic [CW-1:0] deq_eff;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr_p1;
  logic [AW-1:0] wr_ptr_p1;
  logic [63:0]   entry0;
  logic [63:0]   entry1;

  always_comb begin
    free_slots = CW'(DEPTH) - count_q;
    space_ok   = (free_slots >= CW'(2));
    wr_acc     = wr_en & ~flush & space_ok;
    wr_drop    = wr_en & ~flush & ~space_ok;

    // deq_cnt of 3 is treated as 2; never retire more than is queued.
    case (deq_cnt)
      2'd0:    deq_req = CW'(0);
      2'd1:    deq_req = CW'(1);
      default: deq_req = CW'(2);
    endcase
    deq_eff = (deq_req > count_q) ? count_q : deq_req;

    count_next = count_q + (wr_acc ? CW'(2) : CW'(0)) - deq_eff;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    rd_ptr_p1 = rd_ptr + AW'(1);
    wr_ptr_p1 = wr_ptr + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr + AW'(deq_eff);
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(2);
      end
      count_q <= count_next;
      drop_q  <= wr_drop;
    end
  end

  // Storage is deliberately left out of reset; outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr]    <= wr_data[63:0];
      mem[wr_ptr_p1] <= wr_data[127:64];
    end
  end

  always_comb begin
    entry0     = mem[rd_ptr];
    entry1     = mem[rd_ptr_p1];
    valid0     = (count_q >= CW'(1));
    valid1     = (count_q >= CW'(2));
    instr0     = valid0 ? entry0[63:32] : 32'h0;
    pc0        = valid0 ? entry0[31:0]  : 32'h0;
    instr1     = valid1 ? entry1[63:32] : 32'h0;
    pc1        = valid1 ? entry1[31:0]  : 32'h0;
    count      = count_q;
    stop_fetch = (free_slots < CW'(AF_MARGIN));
    drop_err   = drop_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (DEPTH 8, AF_MARGIN 4)

module tb_fetch_queue;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [127:0] wr_data;
  logic         flush;
  logic [1:0]   deq_cnt;
  logic [31:0]  instr0, pc0, instr1, pc1;
  logic         valid0, valid1;
  logic [3:0]   count;
  logic         stop_fetch;
  logic         drop_err;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_queue #(.DEPTH(8), .AF_MARGIN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .flush      (flush),
    .deq_cnt    (deq_cnt),
    .instr0     (instr0),
    .pc0        (pc0),
    .instr1     (instr1),
    .pc1        (pc1),
    .valid0     (valid0),
    .valid1     (valid1),
    .count      (count),
    .stop_fetch (stop_fetch),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr_en;
    logic [127:0] wr_data;
    logic         flush;
    logic [1:0]   deq;
    int           ecount;
    logic         ev0;
    logic         ev1;
    logic [31:0]  epc0;
    logic [31:0]  ei0;
    logic [31:0]  epc1;
    logic [31:0]  ei1;
    logic         estop;
    logic         edrop;
  } vec_t;

  localparam int NV = 23;
  vec_t vec [NV];

  function automatic logic [31:0] ins(input logic [31:0] p);
    return 32'h1000_0000 | p;
  endfunction

  // Pair whose older entry has pc p and younger pc p+4.
  function automatic logic [127:0] mk(input logic [31:0] p);
    return {ins(p + 32'd4), p + 32'd4, ins(p), p};
  endfunction

  function automatic vec_t v(input logic w, input logic [127:0] d, input logic f,
                             input logic [1:0] dq, input int c, input logic v0,
                             input logic v1, input logic [31:0] p0, input logic [31:0] i0,
                             input logic [31:0] p1, input logic [31:0] i1,
                             input logic st, input logic dr);
    vec_t r;
    r.wr_en = w; r.wr_data = d; r.flush = f; r.deq = dq; r.ecount = c;
    r.ev0 = v0; r.ev1 = v1; r.epc0 = p0; r.ei0 = i0; r.epc1 = p1; r.ei1 = i1;
    r.estop = st; r.edrop = dr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [127:0] d, input logic f, input logic [1:0] dq);
    wr_en = w; wr_data = d; flush = f; deq_cnt = dq;
    @(posedge clk);
    #1;
  endtask

  logic [127:0] lit;
  logic [31:0]  exp_pc;

  initial begin
    lit = {32'h00A00093, 32'h00000004, 32'h00100113, 32'h00000000};

    //                 wr  data      fl deq cnt v0 v1 pc0    instr0         pc1    instr1         stop drop
    vec[0]  = v(1, lit,      0, 0, 2, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  0, 0);
    vec[1]  = v(1, mk(8),    0, 0, 4, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  0, 0);
    vec[2]  = v(1, mk(16),   0, 0, 6, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  1, 0);
    vec[3]  = v(1, mk(24),   0, 0, 8, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  1, 0);
    vec[4]  = v(1, mk(32),   0, 0, 8, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  1, 1);
    vec[5]  = v(0, '0,       0, 0, 8, 1, 1, 32'd0,  32'h00100113,  32'd4,  32'h00A00093,  1, 0);
    vec[6]  = v(0, '0,       0, 1, 7, 1, 1, 32'd4,  32'h00A00093,  32'd8,  32'h10000008,  1, 0);
    vec[7]  = v(0, '0,       0, 3, 5, 1, 1, 32'd12, 32'h1000000C,  32'd16, 32'h10000010,  1, 0);
    vec[8]  = v(1, mk(32),   0, 2, 5, 1, 1, 32'd20, 32'h10000014,  32'd24, 32'h10000018,  1, 0);
    vec[9]  = v(0, '0,       0, 2, 3, 1, 1, 32'd28, 32'h1000001C,  32'd32, 32'h10000020,  0, 0);
    vec[10] = v(0, '0,       0, 2, 1, 1, 0, 32'd36, 32'h10000024,  32'd0,  32'h0,         0, 0);
    vec[11] = v(0, '0,       0, 3, 0, 0, 0, 32'd0,  32'h0,         32'd0,  32'h0,         0, 0);
    vec[12] = v(0, '0,       0, 2, 0, 0, 0, 32'd0,  32'h0,         32'd0,  32'h0,         0, 0);
    vec[13] = v(1, mk(40),   0, 0, 2, 1, 1, 32'd40, 32'h10000028,  32'd44, 32'h1000002C,  0, 0);
    vec[14] = v(1, mk(48),   0, 0, 4, 1, 1, 32'd40, 32'h10000028,  32'd44, 32'h1000002C,  0, 0);
    vec[15] = v(1, mk(56),   0, 0, 6, 1, 1, 32'd40, 32'h10000028,  32'd44, 32'h1000002C,  1, 0);
    vec[16] = v(1, mk(64),   1, 2, 0, 0, 0, 32'd0,  32'h0,         32'd0,  32'h0,         0, 0);
    vec[17] = v(1, mk(72),   0, 0, 2, 1, 1, 32'd72, 32'h10000048,  32'd76, 32'h1000004C,  0, 0);
    vec[18] = v(1, mk(80),   0, 0, 4, 1, 1, 32'd72, 32'h10000048,  32'd76, 32'h1000004C,  0, 0);
    vec[19] = v(1, mk(88),   0, 0, 6, 1, 1, 32'd72, 32'h10000048,  32'd76, 32'h1000004C,  1, 0);
    vec[20] = v(1, mk(96),   0, 0, 8, 1, 1, 32'd72, 32'h10000048,  32'd76, 32'h1000004C,  1, 0);
    vec[21] = v(1, mk(104),  1, 0, 0, 0, 0, 32'd0,  32'h0,         32'd0,  32'h0,         0, 0);
    vec[22] = v(1, mk(112),  0, 0, 2, 1, 1, 32'd112,32'h10000070,  32'd116,32'h10000074,  0, 0);

    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0; deq_cnt = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",  32'(count),      32'd0);
    check("rst_valid0", 32'(valid0),     32'd0);
    check("rst_valid1", 32'(valid1),     32'd0);
    check("rst_pc0",    pc0,             32'd0);
    check("rst_instr0", instr0,          32'd0);
    check("rst_stop",   32'(stop_fetch), 32'd0);
    check("rst_drop",   32'(drop_err),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vec[i].wr_en, vec[i].wr_data, vec[i].flush, vec[i].deq);
      check($sformatf("v%0d_count", i),  32'(count),      32'(vec[i].ecount));
      check($sformatf("v%0d_valid0", i), 32'(valid0),     32'(vec[i].ev0));
      check($sformatf("v%0d_valid1", i), 32'(valid1),     32'(vec[i].ev1));
      check($sformatf("v%0d_pc0", i),    pc0,             vec[i].epc0);
      check($sformatf("v%0d_instr0", i), instr0,          vec[i].ei0);
      check($sformatf("v%0d_pc1", i),    pc1,             vec[i].epc1);
      check($sformatf("v%0d_instr1", i), instr1,          vec[i].ei1);
      check($sformatf("v%0d_stop", i),   32'(stop_fetch), 32'(vec[i].estop));
      check($sformatf("v%0d_drop", i),   32'(drop_err),   32'(vec[i].edrop));
    end

    // Wrap: top up to full behind the 112/116 pair, then stream a pair in and
    // two entries out every cycle so both pointers wrap.
    for (int k = 0; k < 3; k++) step(1'b1, mk(32'h100 + 32'(8 * k)), 1'b0, 2'd0);
    check("wrap_full", 32'(count), 32'd8);
    step(1'b0, '0, 1'b0, 2'd2);
    exp_pc = 32'h100;
    check("wrap_pre_count", 32'(count), 32'd6);
    check("wrap_pre_pc0",   pc0,        exp_pc);
    for (int k = 3; k < 9; k++) begin
      step(1'b1, mk(32'h100 + 32'(8 * k)), 1'b0, 2'd2);
      exp_pc = exp_pc + 32'd8;
      check($sformatf("wrap%0d_count", k),  32'(count), 32'd6);
      check($sformatf("wrap%0d_pc0", k),    pc0,        exp_pc);
      check($sformatf("wrap%0d_instr0", k), instr0,     ins(exp_pc));
      check($sformatf("wrap%0d_pc1", k),    pc1,        exp_pc + 32'd4);
      check($sformatf("wrap%0d_drop", k),   32'(drop_err), 32'd0);
    end

    // Asynchronous reset between edges at count 4.
    step(1'b0, '0, 1'b0, 2'd2);
    check("arst_pre_count", 32'(count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count",  32'(count),  32'd0);
    check("arst_valid0", 32'(valid0), 32'd0);
    check("arst_pc0",    pc0,         32'd0);
    check("arst_stop",   32'(stop_fetch), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts a write.
    step(1'b1, mk(32'h300), 1'b0, 2'd0);
    check("post_rst_count", 32'(count), 32'd2);
    check("post_rst_pc0",   pc0,        32'h300);
    check("post_rst_pc1",   pc1,        32'h304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
